// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo shared types: op codes, FSM states
// and small op-decode helpers.
package mdu_hilo_pkg;

  localparam int MDU_OP_W = 2;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_signed(
    input mdu_op_e op
  );
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(
    input mdu_op_e op
  );
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration (combinational).
// In: rem_i, quo_i, dvs_i. Out: rem_o, quo_o.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] sh;
  logic [W:0] diff;

  // sh < 2*dvs, so W+1 bits hold it; diff[W]
  // set means the trial subtract went negative.
  always_comb begin
    sh   = {rem_i, quo_i[W-1]};
    diff = sh - {1'b0, dvs_i};
    if (!diff[W]) begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = sh[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative mult/div unit producing HI/LO.
// Ports: op_valid/op_ready/op_code/op_a/op_b in,
// hilo_alloc/hilo_wb pulses, hi_o/lo_o, busy.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [MDU_OP_W-1:0] op_code,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                hilo_alloc,
  output logic                hilo_wb,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                busy
);

  localparam int AW = 2 * DATA_W;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] a_raw_q, a_raw_d;
  logic              div_q, div_d;
  logic              dz_q, dz_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  mdu_op_e           op;
  logic              accept;
  logic              sgn;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic [DATA_W:0]   mul_sum;
  logic [AW-1:0]     mul_acc;
  logic [DATA_W-1:0] dv_rem;
  logic [DATA_W-1:0] dv_quo;
  logic [AW-1:0]     prod;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  assign op         = mdu_op_e'(op_code);
  assign op_ready   = (state_q == MDU_IDLE);
  assign accept     = op_valid & op_ready;
  assign hilo_alloc = accept;
  assign hilo_wb    = (state_q == MDU_DONE);
  assign busy       = (state_q != MDU_IDLE);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

  // |0x80000000| stays 0x80000000 and is
  // read as unsigned 2^31 by the core.
  assign sgn   = op_is_signed(op);
  assign a_abs = (sgn && op_a[DATA_W-1])
               ? -op_a : op_a;
  assign b_abs = (sgn && op_b[DATA_W-1])
               ? -op_b : op_b;

  // Multiply: acc = {partial, multiplier};
  // add multiplicand on lsb, shift right.
  assign mul_sum = {1'b0, acc_q[AW-1:DATA_W]}
                 + (acc_q[0] ? {1'b0, opnd_q}
                             : '0);
  assign mul_acc = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: acc = {remainder, quotient}.
  mdu_div_step #(
    .W (DATA_W)
  ) u_div_step (
    .rem_i (acc_q[AW-1:DATA_W]),
    .quo_i (acc_q[DATA_W-1:0]),
    .dvs_i (opnd_q),
    .rem_o (dv_rem),
    .quo_o (dv_quo)
  );

  assign prod    = neg_quo_q ? -acc_q : acc_q;
  assign quo_fix = neg_quo_q ? -acc_q[DATA_W-1:0]
                             : acc_q[DATA_W-1:0];
  assign rem_fix = neg_rem_q
                 ? -acc_q[AW-1:DATA_W]
                 : acc_q[AW-1:DATA_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    div_d     = div_q;
    dz_d      = dz_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          state_d   = MDU_CALC;
          cnt_d     = '0;
          div_d     = op_is_div(op);
          dz_d      = op_is_div(op)
                    && (op_b == '0);
          a_raw_d   = op_a;
          neg_quo_d = sgn & (op_a[DATA_W-1]
                    ^ op_b[DATA_W-1]);
          neg_rem_d = sgn & op_a[DATA_W-1];
          if (op_is_div(op)) begin
            acc_d  = {{DATA_W{1'b0}}, a_abs};
            opnd_d = b_abs;
          end else begin
            acc_d  = {{DATA_W{1'b0}}, b_abs};
            opnd_d = a_abs;
          end
        end
      end
      MDU_CALC: begin
        acc_d = div_q ? {dv_rem, dv_quo}
                      : mul_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = MDU_FIX;
        end
      end
      MDU_FIX: begin
        state_d = MDU_DONE;
        if (!div_q) begin
          hi_d = prod[AW-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end else if (dz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      MDU_DONE: begin
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      div_q     <= div_d;
      dz_q      <= dz_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo:
// scoreboard of expected {HI,LO} per op.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hilo_alloc;
  logic        hilo_wb;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];

  mdu_hilo #(
    .DATA_W (32),
    .CNT_W  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .hilo_alloc (hilo_alloc),
    .hilo_wb    (hilo_wb),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {HI, LO}.
  function automatic logic [63:0] model(
    input logic [1:0]  c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = '0;
    case (c)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  task automatic run_op(
    input logic [1:0]  c,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] e,
    input string       nm
  );
    logic [31:0] old_hi, old_lo;
    logic [63:0] exp_v;
    bit seen;
    int lat;
    @(negedge clk);
    old_hi = hi_o;
    old_lo = lo_o;
    op_valid = 1'b1;
    op_code  = c;
    op_a     = a;
    op_b     = b;
    sb_q.push_back(e);
    #1;
    n_tests++;
    if (hilo_alloc !== 1'b1 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s alloc: alloc=%b ready=%b want 1 1",
               nm, hilo_alloc, op_ready);
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
    seen = 0;
    lat  = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_tests++;
        if (op_ready !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy: ready=%b busy=%b want 0 1",
                   nm, op_ready, busy);
        end
      end
      if (k == 33) begin
        n_tests++;
        if (hi_o !== old_hi || lo_o !== old_lo) begin
          n_fail++;
          $display("FAIL %s hold: got %h_%h want %h_%h",
                   nm, hi_o, lo_o, old_hi, old_lo);
        end
      end
      if (hilo_wb === 1'b1) begin
        seen = 1;
        lat  = k;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s wb timeout: no hilo_wb in 40 cycles",
               nm);
      sb_q.delete();
    end else begin
      if (lat != 34) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want 34", nm, lat);
      end
      exp_v = sb_q.pop_front();
      n_tests++;
      if ({hi_o, lo_o} !== exp_v) begin
        n_fail++;
        $display("FAIL %s result: got %h_%h want %h_%h",
                 nm, hi_o, lo_o, exp_v[63:32], exp_v[31:0]);
      end
      @(negedge clk);
      n_tests++;
      if (op_ready !== 1'b1 || hilo_wb !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle: ready=%b wb=%b want 1 0",
                 nm, op_ready, hilo_wb);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({hi_o, lo_o, busy, hilo_wb, hilo_alloc}
        !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_vals: hi=%h lo=%h busy=%b wb=%b",
               hi_o, lo_o, busy, hilo_wb);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b busy=%b want 1 0",
               op_ready, busy);
    end
  endtask

  task automatic test_mult();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,
           64'hFFFF_FFFF_FFFF_FFEB, "mult_neg");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,
           64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    run_op(2'b11, 32'd100, 32'd7,
           {32'd2, 32'd14}, "divu");
    run_op(2'b11, 32'h1234_5678, 32'd0,
           64'h1234_5678_FFFF_FFFF, "divu_by0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000, "div_ovf");
  endtask

  task automatic test_random();
    logic [1:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      c = 2'(i % 4);
      a = $urandom;
      b = (i == 6) ? 32'd0 : $urandom;
      if (i == 5) b = 32'd0 - 32'($urandom_range(1, 9));
      run_op(c, a, b, model(c, a, b), "random");
    end
  endtask

  task automatic test_back_to_back();
    int allocs, wbs, outst;
    logic [63:0] exp_v;
    logic took;
    allocs = 0;
    wbs    = 0;
    outst  = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 2'b01;
    op_a     = 32'd6;
    op_b     = 32'd7;
    for (int cyc = 0; cyc < 90 && wbs < 2; cyc++) begin
      #1;
      took = hilo_alloc;
      if (hilo_alloc === 1'b1) begin
        allocs++;
        outst++;
        sb_q.push_back(model(op_code, op_a, op_b));
        n_tests++;
        if (outst != 1 ||
            cyc != ((allocs == 1) ? 0 : 35)) begin
          n_fail++;
          $display("FAIL b2b alloc: cycle %0d outst %0d",
                   cyc, outst);
        end
      end
      if (cyc >= 1 && cyc <= 34) begin
        n_tests++;
        if (op_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b ready: cycle %0d got %b want 0",
                   cyc, op_ready);
        end
      end
      if (hilo_wb === 1'b1) begin
        wbs++;
        outst--;
        n_tests++;
        if (outst != 0 || sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b pairing: cycle %0d outst %0d",
                   cyc, outst);
        end else begin
          exp_v = sb_q.pop_front();
          if ({hi_o, lo_o} !== exp_v) begin
            n_fail++;
            $display("FAIL b2b result: got %h_%h want %h",
                     hi_o, lo_o, exp_v);
          end
        end
      end
      @(posedge clk);
      #1;
      if (took && allocs == 1) begin
        op_a = 32'd9;
        op_b = 32'd11;
      end
      if (took && allocs == 2) op_valid = 1'b0;
      @(negedge clk);
    end
    op_valid = 1'b0;
    sb_q.delete();
    n_tests++;
    if (allocs != 2 || wbs != 2) begin
      n_fail++;
      $display("FAIL b2b counts: allocs %0d wbs %0d want 2 2",
               allocs, wbs);
    end
  endtask

  task automatic test_reset_mid_op();
    int wbs;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 2'b10;
    op_a     = 32'd1000;
    op_b     = 32'd3;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({hi_o, lo_o, busy, hilo_wb} !== 66'd0) begin
      n_fail++;
      $display("FAIL mid_reset: hi=%h lo=%h busy=%b wb=%b",
               hi_o, lo_o, busy, hilo_wb);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wbs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hilo_wb === 1'b1) wbs++;
    end
    n_tests++;
    if (wbs != 0 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_wb: wbs %0d ready %b want 0 1",
               wbs, op_ready);
    end
    run_op(2'b01, 32'd3, 32'd5, 64'd15, "post_reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit that produces the HI/LO register pair.
- Sits directly upstream of the LO/HI outstanding-write tracker.
  - Pulses hilo_alloc when it accepts an op (feeds the tracker's wreg).
  - Pulses hilo_wb when the HI/LO results are written (feeds the tracker's wreg_wb).
- The tracker's match output stalls MFHI/MFLO readers until hilo_wb arrives.
- Handles one operation at a time: shift-add multiply or restoring divide, 32 iterations each.

Parameters:
- DATA_W, 32, operand width. HI/LO each DATA_W bits; iteration count = DATA_W.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W = DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation request from the execute stage.
- op_ready  out  1  unit can accept an op.
- op_code  in  2  `MduMult=00, `MduMultu=01, `MduDiv=10, `MduDivu=11.
- op_a  in  DATA_W  rs operand (multiplicand / dividend).
- op_b  in  DATA_W  rt operand (multiplier / divisor).
- hilo_alloc  out  1  one-cycle pulse on accept; drives tracker wreg.
- hilo_wb  out  1  one-cycle pulse when hi_o/lo_o hold new results; drives tracker wreg_wb.
- hi_o  out  DATA_W  HI register.
- lo_o  out  DATA_W  LO register.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; hi_o = lo_o = 0; counter = 0.
  - hilo_alloc = 0, hilo_wb = 0, busy = 0.
  - op_ready = 1 once reset deasserts.
- Accept: accept = op_valid & op_ready.
  - op_ready = (state == IDLE).
  - hilo_alloc = accept, combinational, high only in the accept cycle.
  - Operands and op_code are latched at the accept edge.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: on accept, latch the operands and go to CALC with counter = 0.
    - Signed ops latch the absolute values |a| and |b|.
    - Latch neg_q = a[msb]^b[msb] and neg_r = a[msb] for signed ops; both are 0 for unsigned ops.
  - CALC: one iteration per cycle; counter increments each cycle.
    - Multiply: 2*DATA_W accumulator, shift-add on the LSB of the multiplier.
    - Divide: restoring step. Shift remainder:quotient left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
    - After the iteration with counter = DATA_W-1, go to FIX. Counter wraps to 0.
  - FIX: apply sign correction, then write the HI/LO registers.
    - Multiply: negate the 2*DATA_W product if neg_q.
    - Divide: negate the quotient if neg_q; negate the remainder if neg_r.
    - Multiply writes HI = product[2W-1:W], LO = product[W-1:0].
    - Divide writes LO = quotient, HI = remainder.
    - hi_o/lo_o update at the FIX->DONE edge.
  - DONE: hilo_wb = 1 for exactly this one cycle, then go to IDLE.
- Latency:
  - Accept in cycle 0, CALC in cycles 1..32, FIX in cycle 33.
  - hilo_wb is high in cycle 34; the next op can be accepted in cycle 35.
- hi_o/lo_o hold their old values until the FIX->DONE edge. MTHI/MTLO are not handled here.
- Divide by zero (op_b = 0): no exception, fixed result.
  - LO = all ones; HI = the dividend as received (op_a).
  - Still takes the full latency and still pulses hilo_wb.
- Signed overflow (0x80000000 / 0xFFFFFFFF, DIV): LO = 0x80000000, HI = 0.
- Abs of 0x80000000 = 0x80000000, treated as unsigned 2^31. This makes the unsigned core correct without an extra width bit.
- op_valid while busy is ignored (op_ready = 0); no hilo_alloc is produced.
- Every hilo_alloc is followed by exactly one hilo_wb, and never two allocs between wbs. This preserves the tracker's pointer pairing.
- No flush/kill input: an accepted op always completes.
- Reset mid-operation: return immediately to IDLE and clear hi_o/lo_o. No hilo_wb is produced, because the tracker resets on the same rst_n.

Decomposition:
- In defines.v:
  - `MduMult/`MduMultu/`MduDiv/`MduDivu op codes.
  - `MduOpBus width (2).
  - State encodings `MduIdle/`MduCalc/`MduFix/`MduDone.
- hi_o/lo_o and state registers use the existing gnrl_dfflr.
- One natural sub-module: mdu_div_step, a combinational single restoring-divide iteration (remainder, quotient, divisor in; next remainder, quotient out).

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - hilo_alloc in cycle 0 and hilo_wb in cycle 34.
  - HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, hilo_wb still in cycle 34.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Back-to-back with op_valid held high:
  - Second op is accepted in cycle 35 only.
  - Exactly 2 hilo_alloc and 2 hilo_wb pulses, alternating.
  - op_ready=0 in cycles 1..34.
- rst_n low in cycle 10 of a DIV:
  - Outputs return to reset values immediately (async); no hilo_wb ever appears.
  - After release, a new MULTU 3*5 gives LO=15, HI=0.
